// File: rtl/mac_pkg.sv
// Shared definitions for the MAC-array datapath: default widths, the psum
// collector state encoding and beat-count sizing helpers.
package mac_pkg;

  localparam int PSUM_WIDTH_DEF = 5;
  localparam int ACC_WIDTH_DEF  = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } coll_state_e;

  function automatic int beats_f(input int mac_num, input int lanes);
    return mac_num / lanes;
  endfunction

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int idx_width_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/psum_acc_lane.sv
// One per-MAC accumulator: synchronous clear, enable-gated add of a
// zero-extended psum. Saturates when PSUM_COLLECTOR_SAT_EN is defined, else wraps.
module psum_acc_lane
  import mac_pkg::*;
#(
  parameter int PSUM_WIDTH = PSUM_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  add_i,
  input  logic [PSUM_WIDTH-1:0] psum_i,
  output logic [ACC_WIDTH-1:0]  acc_o
);

  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_d;

`ifdef PSUM_COLLECTOR_SAT_EN
  logic [ACC_WIDTH:0] sum_s;

  always_comb begin
    sum_s = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - PSUM_WIDTH){1'b0}}, psum_i};
    if (clr_i) begin
      acc_d = '0;
    end else if (add_i) begin
      // Carry out of the accumulator means the true sum no longer fits.
      if (sum_s[ACC_WIDTH]) begin
        acc_d = '1;
      end else begin
        acc_d = sum_s[ACC_WIDTH-1:0];
      end
    end else begin
      acc_d = acc_q;
    end
  end
`else
  always_comb begin
    if (clr_i) begin
      acc_d = '0;
    end else if (add_i) begin
      acc_d = acc_q + {{(ACC_WIDTH - PSUM_WIDTH){1'b0}}, psum_i};
    end else begin
      acc_d = acc_q;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/psum_collector.sv
// Collects MAC-array psum vectors over channel_count passes into per-MAC
// accumulators, then drains them as LANES-wide beats. Optional macro: PSUM_COLLECTOR_SAT_EN.
module psum_collector
  import mac_pkg::*;
#(
  parameter int MAC_NUM    = 256,
  parameter int PSUM_WIDTH = PSUM_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int LANES      = 16,
  parameter int CH_WIDTH   = 8
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               start,
  input  logic [CH_WIDTH-1:0]                                channel_count,
  input  logic [PSUM_WIDTH*MAC_NUM-1:0]                      psum_in,
  input  logic                                               psum_valid,
  input  logic [MAC_NUM-1:0]                                 enable,
  output logic                                               psum_ready,
  output logic [ACC_WIDTH*LANES-1:0]                         out_data,
  output logic                                               out_valid,
  input  logic                                               out_ready,
  output logic                                               out_last,
  output logic [idx_width_f(beats_f(MAC_NUM, LANES))-1:0]    out_beat_idx,
  output logic                                               busy,
  output logic                                               done
);

  localparam int BEATS  = beats_f(MAC_NUM, LANES);
  localparam int BIDX_W = idx_width_f(BEATS);
  localparam int MAC_W  = idx_width_f(MAC_NUM);

  coll_state_e           state_q;
  coll_state_e           state_d;
  logic [CH_WIDTH-1:0]   remaining_q;
  logic [CH_WIDTH-1:0]   remaining_d;
  logic [BIDX_W-1:0]     beat_idx_q;
  logic [BIDX_W-1:0]     beat_idx_d;
  logic                  acc_clr_s;
  logic                  acc_add_s;
  logic                  done_s;
  logic [MAC_W-1:0]      acc_idx_s;
  logic [ACC_WIDTH-1:0]  acc_s [MAC_NUM];

  genvar g;
  generate
    for (g = 0; g < MAC_NUM; g++) begin : g_lane
      psum_acc_lane #(
        .PSUM_WIDTH (PSUM_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_lane (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (acc_clr_s),
        .add_i  (acc_add_s & enable[g]),
        .psum_i (psum_in[g*PSUM_WIDTH +: PSUM_WIDTH]),
        .acc_o  (acc_s[g])
      );
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    beat_idx_d  = beat_idx_q;
    acc_clr_s   = 1'b0;
    acc_add_s   = 1'b0;
    done_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && (channel_count != '0)) begin
          state_d     = ST_ACCUM;
          remaining_d = channel_count;
          acc_clr_s   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (psum_valid) begin
          acc_add_s   = 1'b1;
          remaining_d = remaining_q - CH_WIDTH'(1);
          if (remaining_q == CH_WIDTH'(1)) begin
            state_d    = ST_DRAIN;
            beat_idx_d = '0;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (beat_idx_q == BIDX_W'(BEATS - 1)) begin
            done_s     = 1'b1;
            state_d    = ST_IDLE;
            beat_idx_d = '0;
          end else begin
            beat_idx_d = beat_idx_q + BIDX_W'(1);
          end
        end else begin
          beat_idx_d = beat_idx_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      beat_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      beat_idx_q  <= beat_idx_d;
    end
  end

  // Beat mux: the data only depends on registered state, so it holds under backpressure.
  always_comb begin
    out_data  = '0;
    acc_idx_s = '0;
    for (int l = 0; l < LANES; l++) begin
      acc_idx_s = MAC_W'(int'(beat_idx_q) * LANES + l);
      out_data[l*ACC_WIDTH +: ACC_WIDTH] = acc_s[acc_idx_s];
    end
  end

  assign psum_ready   = (state_q == ST_ACCUM);
  assign out_valid    = (state_q == ST_DRAIN);
  assign out_last     = (state_q == ST_DRAIN) && (beat_idx_q == BIDX_W'(BEATS - 1));
  assign out_beat_idx = beat_idx_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_s;

endmodule

// File: tb/tb_psum_collector.sv
// Randomized scoreboard bench for psum_collector with a per-MAC arithmetic
// reference model; honours PSUM_COLLECTOR_SAT_EN for the overflow rule.
module tb_psum_collector;

  localparam int MAC_NUM = 256;
  localparam int PW      = 5;
  localparam int AW      = 12;
  localparam int LANES   = 16;
  localparam int CW      = 8;
  localparam int BEATS   = MAC_NUM / LANES;
  localparam int ACC_MAX = (1 << AW) - 1;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic [CW-1:0]           channel_count = '0;
  logic [PW*MAC_NUM-1:0]   psum_in = '0;
  logic                    psum_valid = 1'b0;
  logic [MAC_NUM-1:0]      enable = '0;
  logic                    psum_ready;
  logic [AW*LANES-1:0]     out_data;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic                    out_last;
  logic [3:0]              out_beat_idx;
  logic                    busy;
  logic                    done;

  psum_collector dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .channel_count (channel_count),
    .psum_in       (psum_in),
    .psum_valid    (psum_valid),
    .enable        (enable),
    .psum_ready    (psum_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .out_beat_idx  (out_beat_idx),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW*LANES-1:0] data;
    logic [3:0]          idx;
    logic                last;
  } beat_t;

  beat_t sb[$];
  int    ref_acc [MAC_NUM];
  int    vals[$];
  int    ready_pct = 100;
  int    checks = 0;
  int    errors = 0;
  int    accepts = 0;
  int    done_cnt = 0;

  logic                hold_chk = 1'b0;
  logic [AW*LANES-1:0] h_data;
  logic [3:0]          h_idx;
  logic                h_last;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Downstream backpressure, changed just after each rising edge.
  always @(posedge clk) begin
    #2;
    out_ready = ($urandom_range(99) < ready_pct);
  end

  // Monitor: pops the scoreboard on every handshake and checks hold/done rules.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, h_data);
        chk("hold_idx", out_beat_idx, h_idx);
        chk("hold_last", out_last, h_last);
      end
      if (done) begin
        done_cnt++;
        chk("done_on_last_accept", out_valid && out_ready && out_last, 1);
      end
      if (out_valid && out_ready) begin
        beat_t e;
        accepts++;
        if (sb.size() == 0) begin
          chk("unexpected_beat", out_beat_idx, 4'hx);
        end else begin
          e = sb.pop_front();
          chk("beat_data", out_data, e.data);
          chk("beat_idx", out_beat_idx, e.idx);
          chk("beat_last", out_last, e.last);
        end
      end
      hold_chk = out_valid && !out_ready;
      h_data   = out_data;
      h_idx    = out_beat_idx;
      h_last   = out_last;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_psum_ready"}, psum_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_beat_idx"}, out_beat_idx, 0);
  endtask

  task automatic randomize_psum();
    for (int i = 0; i < MAC_NUM; i++) psum_in[i*PW +: PW] = PW'($urandom_range(31));
  endtask

  task automatic run_job(input int cnt, input logic [MAC_NUM-1:0] en, input int gap_pct,
                         input bit inj_start, input bit pause, input bit abort, input bit noise);
    int acc0;
    int done0;
    int n;
    int pstate;
    int p;
    beat_t e;
    acc0  = accepts;
    done0 = done_cnt;
    @(negedge clk);
    start         = 1'b1;
    channel_count = CW'(cnt);
    enable        = en;
    psum_valid    = 1'b0;
    for (int i = 0; i < MAC_NUM; i++) ref_acc[i] = 0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("psum_ready_in_accum", psum_ready, 1);
    for (int k = 0; k < cnt; k++) begin
      while ($urandom_range(99) < gap_pct) begin
        psum_valid = 1'b0;
        randomize_psum();
        @(negedge clk);
        chk("psum_ready_in_gap", psum_ready, 1);
      end
      for (int i = 0; i < MAC_NUM; i++) begin
        p = (k < vals.size()) ? vals[k] : int'($urandom_range(25));
        psum_in[i*PW +: PW] = PW'(p);
        if (en[i]) begin
          ref_acc[i] = ref_acc[i] + p;
`ifdef PSUM_COLLECTOR_SAT_EN
          if (ref_acc[i] > ACC_MAX) ref_acc[i] = ACC_MAX;
`else
          ref_acc[i] = ref_acc[i] % (ACC_MAX + 1);
`endif
        end
      end
      psum_valid = 1'b1;
      if (inj_start && k == 0) begin
        start         = 1'b1;
        channel_count = CW'(cnt + 7);
      end
      chk("psum_ready_on_accept", psum_ready, 1);
      if (k == cnt - 1) begin
        for (int b = 0; b < BEATS; b++) begin
          for (int l = 0; l < LANES; l++) e.data[l*AW +: AW] = AW'(ref_acc[b*LANES + l]);
          e.idx  = 4'(b);
          e.last = (b == BEATS - 1);
          sb.push_back(e);
        end
      end
      @(negedge clk);
      start      = 1'b0;
      psum_valid = 1'b0;
    end
    chk("psum_ready_drop", psum_ready, 0);
    chk("out_valid_latency", out_valid, 1);
    n      = 0;
    pstate = 0;
    while (busy && n < 3000) begin
      if (abort && out_beat_idx == 4'd5) break;
      if (pause) begin
        if (pstate == 0 && out_beat_idx == 4'd3) begin
          ready_pct = 0;
          pstate    = 1;
        end else if (pstate >= 1 && pstate <= 3) begin
          chk("pause_idx", out_beat_idx, 4);
          chk("pause_ready_low", out_ready, 0);
          if (pstate == 3) ready_pct = 100;
          pstate++;
        end
      end
      if (noise) begin
        psum_valid = 1'($urandom_range(1));
        randomize_psum();
        start         = ($urandom_range(9) == 0);
        channel_count = CW'($urandom_range(255, 1));
        chk("psum_ready_in_drain", psum_ready, 0);
      end
      @(negedge clk);
      start      = 1'b0;
      psum_valid = 1'b0;
      n++;
    end
    chk("drain_timeout", n < 3000, 1);
    if (abort) begin
      #1 rst_n = 1'b0;
      #1 chk_reset_outputs("abort");
      sb.delete();
      @(negedge clk);
      chk("abort_no_done", done_cnt - done0, 0);
      chk_reset_outputs("abort_hold");
      rst_n = 1'b1;
    end else begin
      chk("accept_count", accepts - acc0, BEATS);
      chk("done_count", done_cnt - done0, 1);
      chk("sb_empty", sb.size(), 0);
      chk("idle_after_done", busy, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MAC_NUM-1:0] all_en;
    logic [MAC_NUM-1:0] odd_en;
    logic [MAC_NUM-1:0] rnd_en;
    all_en = '1;
    odd_en = {128{2'b10}};
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Zero channel count must not start a job.
    @(negedge clk);
    start = 1'b1; channel_count = '0; psum_valid = 1'b1;
    @(negedge clk);
    start = 1'b0; psum_valid = 1'b0;
    chk("zero_count_ignored", busy, 0);
    chk("psum_ready_idle", psum_ready, 0);

    ready_pct = 100;
    vals = '{7};
    run_job(1, all_en, 0, 0, 0, 0, 0);
    vals = '{25, 25, 10};
    run_job(3, all_en, 60, 0, 0, 0, 0);
    vals = '{9, 9};
    run_job(2, odd_en, 0, 0, 0, 0, 0);
    vals = {};
    run_job(4, all_en, 0, 0, 1, 0, 0);

    vals = {};
    for (int k = 0; k < 200; k++) vals.push_back(25);
    run_job(200, all_en, 0, 0, 0, 0, 0);

    vals = {};
    for (int i = 0; i < MAC_NUM; i++) rnd_en[i] = 1'($urandom_range(1));
    run_job(3, rnd_en, 0, 1, 0, 1, 0);
    run_job(2, all_en, 20, 0, 0, 0, 0);

    for (int j = 0; j < 6; j++) begin
      ready_pct = 70;
      for (int i = 0; i < MAC_NUM; i++) rnd_en[i] = 1'($urandom_range(1));
      run_job(int'($urandom_range(20, 1)), rnd_en, 30, 1, 0, 0, 1);
    end
    ready_pct = 50;
    run_job(255, all_en, 10, 0, 0, 0, 1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
